// File: rtl/interp_filt_pkg.sv
// Shared helpers for the filter datapath: saturation limits and width helpers
// used by every saturating block.
package interp_filt_pkg;

   // Extra accumulator bits needed to sum n samples without wrapping.
   function automatic int pad_width(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   // Counter width for a 0..n-1 phase, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/sat_trunc.sv
// Combinational signed saturation from IN_WIDTH down to OUT_WIDTH, with a
// flag that reports whether clamping took place.
module sat_trunc
   import interp_filt_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 6
)
(
   input  logic signed [IN_WIDTH-1:0]  in,
   output logic signed [OUT_WIDTH-1:0] out,
   output logic                        sat
);

   localparam logic signed [IN_WIDTH-1:0]  MAX_IN  = IN_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [IN_WIDTH-1:0]  MIN_IN  = IN_WIDTH'(sat_min(OUT_WIDTH));
   localparam logic signed [OUT_WIDTH-1:0] MAX_OUT = OUT_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [OUT_WIDTH-1:0] MIN_OUT = OUT_WIDTH'(sat_min(OUT_WIDTH));

   always_comb begin
      out = in[OUT_WIDTH-1:0];
      sat = 1'b0;
      if (in > MAX_IN) begin
         out = MAX_OUT;
         sat = 1'b1;
      end else if (in < MIN_IN) begin
         out = MIN_OUT;
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/decim_acc_sat.sv
// Integrate-and-dump decimator: sums DECIM signed samples at full width and
// emits one saturated result per group through a registered output stage.
module decim_acc_sat
   import interp_filt_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int DECIM      = 2
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_sat
);

   localparam int ACC_W = DATA_WIDTH + pad_width(DECIM);
   localparam int PH_W  = cnt_width(DECIM);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

   logic signed [ACC_W-1:0]      acc_reg, acc_next;
   logic [PH_W-1:0]              phase_reg, phase_next;
   logic                         out_valid_reg, out_valid_next;
   logic signed [DATA_WIDTH-1:0] out_data_reg, out_data_next;
   logic                         out_sat_reg, out_sat_next;

   logic                         accept;
   logic                         dump;
   logic signed [ACC_W-1:0]      acc_base;
   logic [PH_W-1:0]              phase_base;
   logic signed [ACC_W-1:0]      sum;
   logic signed [DATA_WIDTH-1:0] sat_data;
   logic                         sat_flag;

   assign in_ready = !out_valid_reg || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle as an accept makes this sample the first of a new group.
   assign acc_base   = in_clear ? '0 : acc_reg;
   assign phase_base = in_clear ? '0 : phase_reg;
   assign sum        = acc_base + ACC_W'(in_data);
   assign dump       = accept && (phase_base == PH_LAST);

   sat_trunc #(
      .IN_WIDTH  (ACC_W),
      .OUT_WIDTH (DATA_WIDTH)
   ) u_sat (
      .in  (sum),
      .out (sat_data),
      .sat (sat_flag)
   );

   always_comb begin
      acc_next       = acc_reg;
      phase_next     = phase_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_sat_next   = out_sat_reg;

      if (in_clear) begin
         acc_next   = '0;
         phase_next = '0;
      end

      if (out_valid_reg && out_ready)
         out_valid_next = 1'b0;

      if (accept) begin
         if (dump) begin
            acc_next       = '0;
            phase_next     = '0;
            out_valid_next = 1'b1;
            out_data_next  = sat_data;
            out_sat_next   = sat_flag;
         end else begin
            acc_next   = sum;
            phase_next = phase_base + PH_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         phase_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sat_reg   <= 1'b0;
      end else begin
         acc_reg       <= acc_next;
         phase_reg     <= phase_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_sat_reg   <= out_sat_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_decim_acc_sat.sv
// Bench for decim_acc_sat: directed vector table, hand-written reset/corner
// sequences, and randomized traffic against a group-sum reference model.
module tb_decim_acc_sat;

   localparam int DW = 6;

   logic clk = 1'b0;
   logic rst;

   logic a_clear, a_valid, a_ready, a_ov, a_or, a_os;
   logic signed [DW-1:0] a_din, a_dout;
   logic b_clear, b_valid, b_ready, b_ov, b_or, b_os;
   logic signed [DW-1:0] b_din, b_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decim_acc_sat #(.DATA_WIDTH(DW), .DECIM(4)) dut_a (
      .clk(clk), .rst(rst), .in_clear(a_clear), .in_valid(a_valid), .in_ready(a_ready),
      .in_data(a_din), .out_valid(a_ov), .out_ready(a_or), .out_data(a_dout), .out_sat(a_os)
   );

   decim_acc_sat #(.DATA_WIDTH(DW), .DECIM(1)) dut_b (
      .clk(clk), .rst(rst), .in_clear(b_clear), .in_valid(b_valid), .in_ready(b_ready),
      .in_data(b_din), .out_valid(b_ov), .out_ready(b_or), .out_data(b_dout), .out_sat(b_os)
   );

   // Reference model: running group sum and sample count, plus the output slot.
   typedef struct {
      int sum;
      int cnt;
      bit ov;
      int od;
      bit os;
   } model_t;

   model_t ma, mb;

   function automatic bit mready(model_t m, bit ordy);
      return !m.ov || ordy;
   endfunction

   function automatic model_t mstep(model_t m, int decim, bit clr, bit v, int d, bit ordy);
      model_t r;
      bit take;
      r = m;
      take = v && mready(m, ordy);
      if (clr) begin
         r.sum = 0;
         r.cnt = 0;
      end
      if (m.ov && ordy) r.ov = 1'b0;
      if (take) begin
         r.sum = r.sum + d;
         r.cnt = r.cnt + 1;
         if (r.cnt == decim) begin
            r.ov = 1'b1;
            if (r.sum > 31)       begin r.od = 31;    r.os = 1'b1; end
            else if (r.sum < -32) begin r.od = -32;   r.os = 1'b1; end
            else                  begin r.od = r.sum; r.os = 1'b0; end
            r.sum = 0;
            r.cnt = 0;
         end
      end
      return r;
   endfunction

   function automatic model_t mreset();
      model_t r;
      r.sum = 0; r.cnt = 0; r.ov = 1'b0; r.od = 0; r.os = 1'b0;
      return r;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(bit clr, bit v, int d, bit o);
      a_clear = clr;
      a_valid = v;
      a_din   = DW'(d);
      a_or    = o;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ma = mreset();
      mb = mreset();
   endtask

   typedef struct {
      bit clr; bit v; int d; bit o;
      bit e_rdy; bit e_ov; int e_od; bit e_os;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit clr, bit v, int d, bit o, bit er, bit eov, int eod, bit eos);
      vec_t t;
      t.clr = clr; t.v = v; t.d = d; t.o = o;
      t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_os = eos;
      return t;
   endfunction

   initial begin
      int outs;
      int seen;
      bit c, v, o, bv, bo;
      int d, bd;

      a_clear = 0; a_valid = 0; a_din = '0; a_or = 1;
      b_clear = 0; b_valid = 0; b_din = '0; b_or = 1;
      do_reset();

      chk("reset a out_valid", a_ov, 0);
      chk("reset a out_data", a_dout, 0);
      chk("reset a out_sat", a_os, 0);
      chk("reset a in_ready", a_ready, 1);
      chk("reset b out_valid", b_ov, 0);

      // clr v d or | rdy ov od sat (outputs after the edge)
      tbl.push_back(mk(0,1,  1,1, 1,0,  0,0));
      tbl.push_back(mk(0,1,  2,1, 1,0,  0,0));
      tbl.push_back(mk(0,1,  3,1, 1,0,  0,0));
      tbl.push_back(mk(0,1,  4,1, 1,1, 10,0));
      tbl.push_back(mk(0,0,  0,1, 1,0, 10,0));
      tbl.push_back(mk(0,1, 10,1, 1,0, 10,0));
      tbl.push_back(mk(0,1, 10,1, 1,0, 10,0));
      tbl.push_back(mk(0,1, 10,1, 1,0, 10,0));
      tbl.push_back(mk(0,1, 10,1, 1,1, 31,1));
      tbl.push_back(mk(0,1,-20,1, 1,0, 31,1));
      tbl.push_back(mk(0,1,-20,1, 1,0, 31,1));
      tbl.push_back(mk(0,1,  5,1, 1,0, 31,1));
      tbl.push_back(mk(0,1,  2,1, 1,1,-32,1));
      tbl.push_back(mk(0,1, -8,1, 1,0,-32,1));
      tbl.push_back(mk(0,1, -8,1, 1,0,-32,1));
      tbl.push_back(mk(0,1, -8,1, 1,0,-32,1));
      tbl.push_back(mk(0,1, -8,1, 1,1,-32,0));
      tbl.push_back(mk(0,1,  1,1, 1,0,-32,0));
      tbl.push_back(mk(0,1,  2,1, 1,0,-32,0));
      tbl.push_back(mk(0,1,  3,1, 1,0,-32,0));
      tbl.push_back(mk(0,1,  4,1, 1,1, 10,0));
      tbl.push_back(mk(0,1,  5,0, 0,1, 10,0));
      tbl.push_back(mk(0,1,  5,0, 0,1, 10,0));
      tbl.push_back(mk(0,1,  5,1, 1,0, 10,0));
      tbl.push_back(mk(0,1,  5,1, 1,0, 10,0));
      tbl.push_back(mk(0,1,  5,1, 1,0, 10,0));
      tbl.push_back(mk(0,1,  5,1, 1,1, 20,0));
      tbl.push_back(mk(0,0,  0,1, 1,0, 20,0));
      tbl.push_back(mk(0,1,  7,1, 1,0, 20,0));
      tbl.push_back(mk(0,1,  7,1, 1,0, 20,0));
      tbl.push_back(mk(1,1,  3,1, 1,0, 20,0));
      tbl.push_back(mk(0,1,  3,1, 1,0, 20,0));
      tbl.push_back(mk(0,1,  3,1, 1,0, 20,0));
      tbl.push_back(mk(0,1,  3,1, 1,1, 12,0));
      tbl.push_back(mk(0,0,  0,1, 1,0, 12,0));

      for (int i = 0; i < tbl.size(); i++) begin
         a_clear = tbl[i].clr;
         a_valid = tbl[i].v;
         a_din   = DW'(tbl[i].d);
         a_or    = tbl[i].o;
         #1;
         chk($sformatf("vec%0d in_ready", i), a_ready, tbl[i].e_rdy);
         step();
         chk($sformatf("vec%0d out_valid", i), a_ov, tbl[i].e_ov);
         chk($sformatf("vec%0d out_data", i), a_dout, tbl[i].e_od);
         chk($sformatf("vec%0d out_sat", i), a_os, tbl[i].e_os);
         $display("vec %0d: clr=%0d v=%0d d=%0d or=%0d -> ov=%0d od=%0d sat=%0d",
                  i, tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].o, a_ov, a_dout, a_os);
      end

      // Reset in the middle of a group, then again with a pending output.
      drive_a(0, 1, 1, 1);
      drive_a(0, 1, 1, 1);
      a_valid = 1; a_din = DW'(1); rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midreset out_valid", a_ov, 0);
      chk("midreset out_data", a_dout, 0);
      chk("midreset out_sat", a_os, 0);
      for (int i = 0; i < 4; i++) drive_a(0, 1, 1, 0);
      chk("post-reset group valid", a_ov, 1);
      chk("post-reset group data", a_dout, 4);
      a_valid = 0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("pending dropped by reset", a_ov, 0);
      for (int i = 0; i < 4; i++) drive_a(0, 1, 1, 1);
      chk("regroup data", a_dout, 4);
      chk("regroup valid", a_ov, 1);
      drive_a(0, 0, 0, 1);
      $display("reset sequence done");

      // DECIM=1 pass-through.
      b_valid = 1; b_din = DW'(31); b_or = 1;
      step();
      chk("decim1 valid", b_ov, 1);
      chk("decim1 data 31", b_dout, 31);
      chk("decim1 sat", b_os, 0);
      b_din = DW'(-32);
      step();
      chk("decim1 data -32", b_dout, -32);
      b_valid = 0;
      step();
      chk("decim1 drained", b_ov, 0);
      $display("decim1 pass-through done");

      // Continuous stream: 16 samples, exactly 4 outputs at 4-cycle spacing.
      do_reset();
      outs = 0;
      for (int i = 0; i < 16; i++) begin
         d = int'($urandom_range(0, 63)) - 32;
         a_clear = 0; a_valid = 1; a_din = DW'(d); a_or = 1;
         #1;
         chk($sformatf("stream%0d in_ready", i), a_ready, 1);
         step();
         ma = mstep(ma, 4, 0, 1, d, 1);
         chk($sformatf("stream%0d out_valid", i), a_ov, (i % 4 == 3) ? 1 : 0);
         if (a_ov) begin
            outs++;
            chk($sformatf("stream%0d out_data", i), a_dout, ma.od);
            chk($sformatf("stream%0d out_sat", i), a_os, ma.os);
            $display("stream out: data=%0d sat=%0d", a_dout, a_os);
         end
      end
      chk("stream output count", outs, 4);
      a_valid = 0;

      // Randomized traffic on both instances against the reference model.
      do_reset();
      seen = 0;
      for (int i = 0; i < 800; i++) begin
         c  = ($urandom_range(0, 15) == 0);
         v  = ($urandom_range(0, 3) != 0);
         o  = ($urandom_range(0, 3) != 0);
         d  = int'($urandom_range(0, 63)) - 32;
         bv = ($urandom_range(0, 2) != 0);
         bo = ($urandom_range(0, 2) != 0);
         bd = int'($urandom_range(0, 63)) - 32;
         a_clear = c; a_valid = v; a_din = DW'(d); a_or = o;
         b_clear = ($urandom_range(0, 7) == 0); b_valid = bv; b_din = DW'(bd); b_or = bo;
         #1;
         chk($sformatf("rand%0d a in_ready", i), a_ready, mready(ma, o));
         chk($sformatf("rand%0d b in_ready", i), b_ready, mready(mb, bo));
         step();
         ma = mstep(ma, 4, c, v, d, o);
         mb = mstep(mb, 1, b_clear, bv, bd, bo);
         chk($sformatf("rand%0d a out_valid", i), a_ov, ma.ov);
         chk($sformatf("rand%0d a out_data", i), a_dout, ma.od);
         chk($sformatf("rand%0d a out_sat", i), a_os, ma.os);
         chk($sformatf("rand%0d b out_valid", i), b_ov, mb.ov);
         chk($sformatf("rand%0d b out_data", i), b_dout, mb.od);
         chk($sformatf("rand%0d b out_sat", i), b_os, mb.os);
         if (a_ov && o) seen++;
      end
      $display("random phase: %0d outputs transferred from decim-4 instance", seen);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
